// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Config changes take effect only at period boundaries, disable, or align.
module clk_div_multi #(
  parameter int CH          = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       load,
  input  logic [CH*DIV_W-1:0] div_i,
  input  logic [CH*DIV_W-1:0] high_i,
  input  logic                align,
  output logic [CH-1:0]       clk_out,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       cfg_err
);

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] HIGH_RST = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] high_q, high_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] phigh_q, phigh_d;
    logic             pval_q, pval_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [DIV_W-1:0] ndiv, nhigh;
    logic             ok, wrap, apply, take;

    assign ndiv  = div_i[i*DIV_W +: DIV_W];
    assign nhigh = high_i[i*DIV_W +: DIV_W];
    assign ok    = (ndiv >= TWO) && (nhigh != '0) && (nhigh < ndiv);
    assign wrap  = (cnt_q == div_q - ONE);
    assign apply = align || !en[i] || wrap;
    assign take  = load[i] && ok;

    always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      high_d  = high_q;
      pdiv_d  = pdiv_q;
      phigh_d = phigh_q;
      pval_d  = pval_q;
      clk_d   = clk_q;
      tick_d  = tick_q;
      err_d   = load[i] && !ok;
      if (align || !en[i]) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
      end else begin
        cnt_d  = wrap ? '0 : cnt_q + ONE;
        clk_d  = (cnt_q < high_q);
        tick_d = wrap;
      end
      // An incoming valid load on an apply edge wins over the pending one.
      if (apply) begin
        pval_d = 1'b0;
        if (take) begin
          div_d  = ndiv;
          high_d = nhigh;
        end else if (pval_q) begin
          div_d  = pdiv_q;
          high_d = phigh_q;
        end
      end else if (take) begin
        pdiv_d  = ndiv;
        phigh_d = nhigh;
        pval_d  = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        div_q   <= DIV_RST;
        high_q  <= HIGH_RST;
        pdiv_q  <= '0;
        phigh_q <= '0;
        pval_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        high_q  <= high_d;
        pdiv_q  <= pdiv_d;
        phigh_q <= phigh_d;
        pval_q  <= pval_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        err_q   <= err_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign cfg_err[i] = err_q;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock divider and tick generator. It is the successor to the fixed single-channel toggle divider. Each channel has a runtime-programmable period and high time (duty cycle), a per-channel enable, glitch-free reconfiguration at period boundaries, and a common phase-align strobe. It generates slow read/write clocks and rate ticks for FIFO test and integration.

Parameters:
CH, 2, number of independent divider channels (>=1)
DIV_W, 16, width of counter, divisor and high-time fields
DEFAULT_DIV, 10, period in clk cycles after reset (>=2, < 2**DIV_W)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en  input  CH  per-channel enable; 0 = channel idle
load  input  CH  per-channel config strobe, one cycle
div_i  input  CH*DIV_W  new period in clk cycles; channel i at [i*DIV_W +: DIV_W]
high_i  input  CH*DIV_W  new high time in clk cycles; same packing
align  input  1  synchronous restart of all channels in phase
clk_out  output  CH  divided clock, registered
tick  output  CH  one-cycle pulse, last cycle of each period
cfg_err  output  CH  one-cycle pulse, rejected load

Behaviour:
- Reset (async): cnt=0, div_r=DEFAULT_DIV, high_r=DEFAULT_DIV/2 (integer), pend_valid=0, clk_out=0, tick=0, cfg_err=0.
- Per-channel state: cnt[DIV_W], active div_r/high_r, pending pend_div/pend_high/pend_valid. All outputs are registered.
- Enabled (en=1), per edge:
  - cnt <= (cnt==div_r-1) ? 0 : cnt+1
  - clk_out <= (cnt < high_r)
  - tick <= (cnt == div_r-1)
  - Result: after the first enabled edge, clk_out is high high_r cycles, then low div_r-high_r cycles, repeating.
  - tick is high during the final low cycle; clk_out rises on the next edge.
- Disabled (en=0): cnt<=0, clk_out<=0, tick<=0. Re-enable always starts with a full high phase.
- Config validity: div_i>=2 and 1<=high_i<=div_i-1.
  - Valid load: pend_div/pend_high captured, pend_valid<=1. A later load before apply overwrites the pending value.
  - Invalid load: cfg_err<=1 for one cycle; pending and active config unchanged.
- Apply (pending -> active, pend_valid<=0) occurs at:
  - an enabled edge with cnt==div_r-1 (period boundary), or
  - any edge with en=0, or
  - an align edge.
  - The new config governs the cycle whose cnt is 0.
  - A waveform never shows a truncated or stretched period from a config change.
- Load on an apply edge: a valid incoming load is applied directly (bypasses pending), and pend_valid<=0.
- align=1: every channel sets cnt<=0, clk_out<=0, tick<=0, and applies pending. align overrides the wrap and enable logic for that edge. All enabled channels rise together on the following edge.
- Arithmetic: comparisons are unsigned DIV_W-bit. No counter ever exceeds div_r-1. Max period is 2**DIV_W-1.
- Async reset mid-operation: outputs drop immediately; pending config is discarded.

Test Plan:
1. CH=2, DEFAULT_DIV=10, release reset, en=2'b01 -> clk_out[0] 5 high/5 low, tick[0] every 10 cycles. Channel 1 stays 0.
2. Ch0 running div 10, load div_i=4 high_i=1 at cnt=3 -> current 10-cycle period completes unchanged, then 1 high/3 low. tick spacing is 10 then 4.
3. Load div_i=1 (also high_i=0, high_i=div_i) -> cfg_err pulses exactly one cycle after each; waveform and period unchanged.
4. Drop en mid-high-phase -> clk_out 0 on next edge and tick never fires. Re-enable -> full 5-cycle high phase first.
5. Ch0 div 6, ch1 div 9, both running, pulse align -> both clk_out rise on the same edge two cycles after align asserted. Coincident ticks every 18 cycles.
6. Load valid config then assert rst_n=0 before boundary -> outputs 0 asynchronously. After release the default div 10/high 5 is used and no pending apply occurs.
